// File: rtl/fpu_round_pack_if.sv
// Valid/ready bus carrying one extended-precision result into the
// round/pack stage and the packed binary32 word plus fflags back out.
`timescale 1ns/1ps
interface fpu_round_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_sig;
    logic        in_sticky;
    logic [2:0]  in_rm;
    logic        in_nan;
    logic        in_inf;
    logic        in_nv;
    logic        in_dz;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_sticky, in_rm,
        output in_nan, in_inf, in_nv, in_dz, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_sticky, in_rm,
        input  in_nan, in_inf, in_nv, in_dz, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/fpu_round_pack.sv
// Two-stage normalize + round/pack to IEEE binary32 with RISC-V fflags.
// Define FPU_PACK_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to zero.
`timescale 1ns/1ps
module fpu_round_pack (
    input logic clk,
    input logic rst_n,
    fpu_round_pack_if.slave bus
);
    logic s1_valid, s2_valid, s1_adv, s2_adv;

    logic        s1_sign, s1_sticky, s1_nan, s1_inf, s1_nv, s1_dz;
    logic        s1_zero, s1_flush;
    logic [9:0]  s1_exp;
    logic [26:0] s1_sig;
    logic [2:0]  s1_rm;

    logic [4:0]         lz;
    logic [26:0]        nsig, dsig;
    logic signed [11:0] adj;
    logic               dst, n_zero, n_flush;
    logic [9:0]         nexp;
`ifdef FPU_PACK_SUBNORMAL_EN
    logic signed [11:0] sh12;
    logic [4:0]         sh;
`endif

    logic [23:0] keep;
    logic        grd, stk, inx, up, ovf, sat;
    logic        rtz, rdn, rup, rmm;
    logic [24:0] sum;
    logic [22:0] mant;
    logic [10:0] base, rexp;
    logic [31:0] res;
    logic [4:0]  flg;

    assign s2_adv        = ~s2_valid | bus.out_ready;
    assign s1_adv        = ~s1_valid | s2_adv;
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;

    // Leading-zero count: the highest set bit wins.
    always_comb begin
        lz = '0;
        for (int i = 0; i < 27; i++)
            if (bus.in_sig[i]) lz = 5'(26 - i);
    end

    // Normalize, then denormalize or flush when the exponent underflows.
    always_comb begin
        nsig    = bus.in_sig << lz;
        adj     = $signed({{2{bus.in_exp[9]}}, bus.in_exp})
                - $signed({7'd0, lz});
        n_zero  = ~|bus.in_sig;
        n_flush = 1'b0;
        dsig    = nsig;
        dst     = 1'b0;
        nexp    = adj[9:0];
`ifdef FPU_PACK_SUBNORMAL_EN
        sh12    = 12'sd1 - adj;
        sh      = (sh12 > 12'sd27) ? 5'd27 : sh12[4:0];
`endif
        if (n_zero) begin
            dsig = '0;
            nexp = '0;
        end else if (adj <= 12'sd0) begin
`ifdef FPU_PACK_SUBNORMAL_EN
            dsig = nsig >> sh;
            dst  = |(nsig & ~(27'h7FFFFFF << sh));
            nexp = '0;
`else
            n_flush = 1'b1;
            dsig    = '0;
            nexp    = '0;
`endif
        end
    end

    // Stage 1 register: normalized operand and control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= '0;
            s1_sig    <= '0;
            s1_sticky <= 1'b0;
            s1_rm     <= '0;
            s1_nan    <= 1'b0;
            s1_inf    <= 1'b0;
            s1_nv     <= 1'b0;
            s1_dz     <= 1'b0;
            s1_zero   <= 1'b0;
            s1_flush  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign   <= bus.in_sign;
                s1_exp    <= nexp;
                s1_sig    <= dsig;
                s1_sticky <= bus.in_sticky | dst;
                s1_rm     <= bus.in_rm;
                s1_nan    <= bus.in_nan;
                s1_inf    <= bus.in_inf;
                s1_nv     <= bus.in_nv;
                s1_dz     <= bus.in_dz;
                s1_zero   <= n_zero;
                s1_flush  <= n_flush;
            end
        end
    end

    // Round, detect overflow/underflow and pack the result word.
    always_comb begin
        keep = s1_sig[26:3];
        grd  = s1_sig[2];
        stk  = |s1_sig[1:0] | s1_sticky;
        inx  = grd | stk;
        rtz  = (s1_rm == 3'b001);
        rdn  = (s1_rm == 3'b010);
        rup  = (s1_rm == 3'b011);
        rmm  = (s1_rm == 3'b100);
        unique case (1'b1)
            rtz:     up = 1'b0;
            rdn:     up = s1_sign & inx;
            rup:     up = ~s1_sign & inx;
            rmm:     up = grd;
            default: up = grd & (stk | keep[0]);
        endcase
        sum  = {1'b0, keep} + {24'd0, up};
        base = {1'b0, s1_exp};
        if (sum[24]) begin
            mant = sum[23:1];
            rexp = base + 11'd1;
        end else begin
            mant = sum[22:0];
            rexp = base + {10'd0, (s1_exp == 10'd0) & sum[23]};
        end
        ovf = (rexp >= 11'd255);
        sat = rtz | (rdn & ~s1_sign) | (rup & s1_sign);
        flg = {s1_nv, s1_dz, 3'b000};
        if (s1_nan) begin
            res = 32'h7FC00000;
        end else if (s1_inf) begin
            res = {s1_sign, 8'hFF, 23'd0};
        end else if (s1_zero) begin
            res = {s1_sign, 31'd0};
        end else if (s1_flush) begin
            res      = {s1_sign, 31'd0};
            flg[1:0] = 2'b11;
        end else if (ovf) begin
            res    = sat ? {s1_sign, 31'h7F7FFFFF}
                         : {s1_sign, 8'hFF, 23'd0};
            flg[2] = 1'b1;
            flg[0] = 1'b1;
        end else begin
            res    = {s1_sign, rexp[7:0], mant};
            flg[0] = inx;
            flg[1] = inx & (rexp[7:0] == 8'd0);
        end
    end

    // Stage 2 register: holds the packed word while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            bus.out_result <= '0;
            bus.out_flags  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_result <= res;
                bus.out_flags  <= flg;
            end
        end
    end
endmodule
